// File: rtl/sprite_pixel_pipeline_pkg.sv
// vga_pkg: SVGA timing constants, sprite-table entry and pipeline-tag types,
// and memory-word channel slicing helpers shared by the sprite pixel pipeline.
package vga_pkg;

  localparam int H_ACTIVE     = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int X_W          = 11;
  localparam int Y_W          = 10;
  localparam int SPR_ELEM_W   = 3;
  localparam int MAX_CH_W     = 8;
  localparam int MAX_WORD_W   = 3 * MAX_CH_W;

  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } channel_e;

  typedef struct packed {
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic [SPR_ELEM_W-1:0] elem;
    logic                  active;
  } sprite_entry_t;

  typedef struct packed {
    logic valid;
    logic hit;
    logic enable;
  } pipe_tag_t;

  // Channel fields are packed R,G,B from the MSB down, ch_w bits each.
  function automatic logic [MAX_CH_W-1:0] ch_field(input logic [MAX_WORD_W-1:0] word,
                                                   input int ch_w, input channel_e ch);
    return MAX_CH_W'(word >> (ch_w * int'(ch))) & MAX_CH_W'((1 << ch_w) - 1);
  endfunction

  function automatic logic [MAX_CH_W-1:0] ch_top(input logic [MAX_WORD_W-1:0] word,
                                                 input int ch_w, input int color_bits,
                                                 input channel_e ch);
    return ch_field(word, ch_w, ch) >> (ch_w - color_bits);
  endfunction

endpackage

// File: rtl/sprite_pixel_pipeline_if.sv
// Sprite memory read bus: strobe, element and offset out; data returns one cycle later.
interface sprite_pixel_pipeline_if #(
  parameter int ELEM_W = 3,
  parameter int ADDR_W = 10,
  parameter int CH_W   = 4
);
  logic                mem_rd_en;
  logic [ELEM_W-1:0]   mem_element;
  logic [ADDR_W-1:0]   mem_address;
  logic [3*CH_W-1:0]   mem_data;

  modport master (output mem_rd_en, output mem_element, output mem_address, input mem_data);
  modport slave  (input mem_rd_en, input mem_element, input mem_address, output mem_data);
endinterface

// File: rtl/sprite_pixel_pipeline_hit.sv
// sprite_hit_unit: decides whether one live sprite covers the current pixel and
// gives the pixel's offset inside that sprite. Bounds use one extra bit so no wrap.
module sprite_hit_unit
  import vga_pkg::*;
#(
  parameter int SPRITE_SIZE = 20,
  parameter int OFF_W       = 5
) (
  input  sprite_entry_t         i_entry,
  input  logic [X_W-1:0]        i_pixel_x,
  input  logic [Y_W-1:0]        i_pixel_y,
  output logic                  o_hit,
  output logic [OFF_W-1:0]      o_off_x,
  output logic [OFF_W-1:0]      o_off_y,
  output logic [SPR_ELEM_W-1:0] o_elem
);

  logic [X_W:0] w_x_end;
  logic [Y_W:0] w_y_end;
  logic         w_in_x;
  logic         w_in_y;

  assign w_x_end = {1'b0, i_entry.x} + (X_W+1)'(SPRITE_SIZE);
  assign w_y_end = {1'b0, i_entry.y} + (Y_W+1)'(SPRITE_SIZE);

  assign w_in_x = (i_pixel_x >= i_entry.x) && ({1'b0, i_pixel_x} < w_x_end);
  assign w_in_y = (i_pixel_y >= i_entry.y) && ({1'b0, i_pixel_y} < w_y_end);

  assign o_hit   = i_entry.active && w_in_x && w_in_y;
  assign o_off_x = OFF_W'(i_pixel_x - i_entry.x);
  assign o_off_y = OFF_W'(i_pixel_y - i_entry.y);
  assign o_elem  = i_entry.elem;

endmodule

// File: rtl/sprite_pixel_pipeline.sv
// Sprite pixel pipeline: double-buffered sprite table, priority hit, memory fetch,
// colour key and background, 3-cycle aligned RGB/sync. Option: SPRITE_TRANSPARENCY_EN.
module sprite_pixel_pipeline
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 20,
  parameter int ELEM_W      = SPR_ELEM_W,
  parameter int ADDR_W      = 10,
  parameter int CH_W        = 4,
  parameter int COLOR_BITS  = 3,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter logic [3*CH_W-1:0] BG_COLOR   = 12'h000,
  parameter logic [3*CH_W-1:0] TRANSP_KEY = 12'hF0F,
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [X_W-1:0]         pixel_x,
  input  logic [Y_W-1:0]         pixel_y,
  input  logic                   video_enable,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   reg_wr_en,
  input  logic [SEL_W-1:0]       reg_sel,
  input  logic [X_W-1:0]         reg_x,
  input  logic [Y_W-1:0]         reg_y,
  input  logic [ELEM_W-1:0]      reg_elem,
  input  logic                   reg_active,
  sprite_pixel_pipeline_if.master mem,
  output logic [COLOR_BITS-1:0]  vga_r,
  output logic [COLOR_BITS-1:0]  vga_g,
  output logic [COLOR_BITS-1:0]  vga_b,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   commit
);

  localparam int OFF_W = $clog2(SPRITE_SIZE);

  sprite_entry_t r_shadow [NUM_SPRITES];
  sprite_entry_t r_live   [NUM_SPRITES];
  logic          r_commit;
  logic          w_commit_pt;

  assign w_commit_pt = (pixel_x == '0) && (pixel_y == Y_W'(V_ACTIVE));

  // NOTE: the tables are a handful of flops, not a RAM, so they are reset
  // directly; a real memory macro could not be cleared this way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
      r_commit <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make live take the pre-write shadow
      // when a register write lands in the commit cycle.
      if (reg_wr_en && (int'(reg_sel) < NUM_SPRITES)) begin
        r_shadow[reg_sel] <= '{x: reg_x, y: reg_y, elem: SPR_ELEM_W'(reg_elem),
                               active: reg_active};
      end
      if (w_commit_pt) begin
        for (int i = 0; i < NUM_SPRITES; i++) r_live[i] <= r_shadow[i];
      end
      r_commit <= w_commit_pt;
    end
  end

  logic                  w_hit   [NUM_SPRITES];
  logic [OFF_W-1:0]      w_off_x [NUM_SPRITES];
  logic [OFF_W-1:0]      w_off_y [NUM_SPRITES];
  logic [SPR_ELEM_W-1:0] w_elem  [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_unit #(.SPRITE_SIZE(SPRITE_SIZE), .OFF_W(OFF_W)) u_hit (
      .i_entry   (r_live[g]),
      .i_pixel_x (pixel_x),
      .i_pixel_y (pixel_y),
      .o_hit     (w_hit[g]),
      .o_off_x   (w_off_x[g]),
      .o_off_y   (w_off_y[g]),
      .o_elem    (w_elem[g])
    );
  end

  logic              w_any_hit;
  logic [SEL_W-1:0]  w_win;
  logic [ELEM_W-1:0] w_win_elem;
  logic [ADDR_W-1:0] w_win_addr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_any_hit = 1'b0;
    w_win     = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit = 1'b1;
        w_win     = SEL_W'(i);
      end
    end
  end

  assign w_win_elem = ELEM_W'(w_elem[w_win]);
  assign w_win_addr = ADDR_W'(w_off_y[w_win]) * ADDR_W'(SPRITE_SIZE) + ADDR_W'(w_off_x[w_win]);

  logic              r_mem_rd_en;
  logic [ELEM_W-1:0] r_mem_element;
  logic [ADDR_W-1:0] r_mem_address;
  pipe_tag_t         r_tag1;
  pipe_tag_t         r_tag2;
  logic [2:0]        r_hs_dly;
  logic [2:0]        r_vs_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd_en   <= 1'b0;
      r_mem_element <= '0;
      r_mem_address <= '0;
      r_tag1        <= '0;
      r_tag2        <= '0;
      r_hs_dly      <= '1;
      r_vs_dly      <= '1;
    end else begin
      r_mem_rd_en   <= w_any_hit && video_enable;
      r_mem_element <= (w_any_hit && video_enable) ? w_win_elem : '0;
      r_mem_address <= (w_any_hit && video_enable) ? w_win_addr : '0;
      r_tag1        <= '{valid: 1'b1, hit: w_any_hit && video_enable, enable: video_enable};
      r_tag2        <= r_tag1;
      r_hs_dly      <= {r_hs_dly[1:0], hsync_in};
      r_vs_dly      <= {r_vs_dly[1:0], vsync_in};
    end
  end

  assign mem.mem_rd_en   = r_mem_rd_en;
  assign mem.mem_element = r_mem_element;
  assign mem.mem_address = r_mem_address;

  logic              w_transp;
  logic [3*CH_W-1:0] w_pix;
  logic              w_show;

`ifdef SPRITE_TRANSPARENCY_EN
  assign w_transp = (mem.mem_data == TRANSP_KEY);
`else
  assign w_transp = 1'b0;
`endif

  // Only the winner is fetched, so a keyed-out winner falls back to background.
  always_comb begin
    w_pix = BG_COLOR;
    if (r_tag2.hit && !w_transp) w_pix = mem.mem_data;
  end

  assign w_show = r_tag2.valid && r_tag2.enable;

  logic [COLOR_BITS-1:0] r_vga_r;
  logic [COLOR_BITS-1:0] r_vga_g;
  logic [COLOR_BITS-1:0] r_vga_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
    end else begin
      r_vga_r <= w_show ? COLOR_BITS'(ch_top(MAX_WORD_W'(w_pix), CH_W, COLOR_BITS, CH_R)) : '0;
      r_vga_g <= w_show ? COLOR_BITS'(ch_top(MAX_WORD_W'(w_pix), CH_W, COLOR_BITS, CH_G)) : '0;
      r_vga_b <= w_show ? COLOR_BITS'(ch_top(MAX_WORD_W'(w_pix), CH_W, COLOR_BITS, CH_B)) : '0;
    end
  end

  assign vga_r     = r_vga_r;
  assign vga_g     = r_vga_g;
  assign vga_b     = r_vga_b;
  assign hsync_out = r_hs_dly[2];
  assign vsync_out = r_vs_dly[2];
  assign commit    = r_commit;

endmodule
